// File: rtl/dmi_axi_lite_bridge_if.sv
// DMI request/response and AXI4-Lite master signal bundle for dmi_axi_lite_bridge.
// master = bridge view; slave = DTM/interconnect view.
interface dmi_axi_lite_bridge_if #(
  parameter int unsigned AxiAddrWidth = 32
);
  typedef struct packed {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  dmi_req_t                dmi_req_i;
  logic                    dmi_req_valid_i;
  logic                    dmi_req_ready_o;
  dmi_resp_t               dmi_resp_o;
  logic                    dmi_resp_valid_o;
  logic                    dmi_resp_ready_i;

  logic [AxiAddrWidth-1:0] axi_awaddr_o;
  logic                    axi_awvalid_o;
  logic                    axi_awready_i;
  logic [31:0]             axi_wdata_o;
  logic [3:0]              axi_wstrb_o;
  logic                    axi_wvalid_o;
  logic                    axi_wready_i;
  logic [1:0]              axi_bresp_i;
  logic                    axi_bvalid_i;
  logic                    axi_bready_o;
  logic [AxiAddrWidth-1:0] axi_araddr_o;
  logic                    axi_arvalid_o;
  logic                    axi_arready_i;
  logic [31:0]             axi_rdata_i;
  logic [1:0]              axi_rresp_i;
  logic                    axi_rvalid_i;
  logic                    axi_rready_o;

  modport master (
    input  dmi_req_i, dmi_req_valid_i, dmi_resp_ready_i,
    output dmi_req_ready_o, dmi_resp_o, dmi_resp_valid_o,
    output axi_awaddr_o, axi_awvalid_o, axi_wdata_o, axi_wstrb_o, axi_wvalid_o,
    output axi_bready_o, axi_araddr_o, axi_arvalid_o, axi_rready_o,
    input  axi_awready_i, axi_wready_i, axi_bresp_i, axi_bvalid_i,
    input  axi_arready_i, axi_rdata_i, axi_rresp_i, axi_rvalid_i
  );

  modport slave (
    output dmi_req_i, dmi_req_valid_i, dmi_resp_ready_i,
    input  dmi_req_ready_o, dmi_resp_o, dmi_resp_valid_o,
    input  axi_awaddr_o, axi_awvalid_o, axi_wdata_o, axi_wstrb_o, axi_wvalid_o,
    input  axi_bready_o, axi_araddr_o, axi_arvalid_o, axi_rready_o,
    output axi_awready_i, axi_wready_i, axi_bresp_i, axi_bvalid_i,
    output axi_arready_i, axi_rdata_i, axi_rresp_i, axi_rvalid_i
  );
endinterface

// File: rtl/dmi_axi_lite_bridge.sv
// DMI responder exposing ADDR/DATA/CTRL; DATA/CTRL accesses launch single-beat AXI4-Lite transfers.
// Response 1 cycle after accept, held until consumed; launches answer at once, completion runs in background.
module dmi_axi_lite_bridge #(
  parameter logic [6:0]  AddrBase     = 7'h10,
  parameter int unsigned AxiAddrWidth = 32
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  dmi_axi_lite_bridge_if.master bus
);
  localparam logic [0:0] Idle    = 1'b0;
  localparam logic [0:0] Resp    = 1'b1;
  localparam logic [2:0] AxIdle  = 3'd0;
  localparam logic [2:0] AxWrite = 3'd1;
  localparam logic [2:0] AxB     = 3'd2;
  localparam logic [2:0] AxRead  = 3'd3;
  localparam logic [2:0] AxR     = 3'd4;
  localparam logic [1:0] OpNop   = 2'd0;
  localparam logic [1:0] OpRead  = 2'd1;
  localparam logic [1:0] OpWrite = 2'd2;
  localparam logic [1:0] RspOk   = 2'd0;
  localparam logic [1:0] RspErr  = 2'd2;
  localparam logic [1:0] RspBusy = 2'd3;

  logic [0:0]              r_dmi_state;
  logic [2:0]              r_ax_state;
  logic [AxiAddrWidth-1:0] r_addr;
  logic [31:0]             r_wdata;
  logic [31:0]             r_rdata;
  logic                    r_autoinc;
  logic                    r_sticky;
  logic [1:0]              r_last_resp;
  logic                    r_aw_done;
  logic                    r_w_done;
  logic [31:0]             r_resp_data;
  logic [1:0]              r_resp_code;

  logic        w_busy, w_accept, w_rd, w_wr;
  logic        w_sel_addr, w_sel_data, w_sel_ctrl;
  logic [31:0] w_req_data;
  logic [1:0]  w_code;
  logic [31:0] w_rdat;
  logic        w_ld_addr, w_ld_ctrl, w_clr, w_go_wr, w_go_rd;
  logic        w_aw_hs, w_w_hs, w_cpl, w_cpl_err;
  logic [1:0]  w_cpl_resp;

  assign w_busy     = (r_ax_state != AxIdle);
  assign w_accept   = bus.dmi_req_valid_i && (r_dmi_state == Idle);
  assign w_rd       = (bus.dmi_req_i.op == OpRead);
  assign w_wr       = (bus.dmi_req_i.op == OpWrite);
  assign w_sel_addr = (bus.dmi_req_i.addr == AddrBase);
  assign w_sel_data = (bus.dmi_req_i.addr == AddrBase + 7'd1);
  assign w_sel_ctrl = (bus.dmi_req_i.addr == AddrBase + 7'd2);
  assign w_req_data = bus.dmi_req_i.data;

  assign w_aw_hs    = bus.axi_awvalid_o && bus.axi_awready_i;
  assign w_w_hs     = bus.axi_wvalid_o && bus.axi_wready_i;
  assign w_cpl      = ((r_ax_state == AxB) && bus.axi_bvalid_i) ||
                      ((r_ax_state == AxR) && bus.axi_rvalid_i);
  assign w_cpl_resp = (r_ax_state == AxB) ? bus.axi_bresp_i : bus.axi_rresp_i;
  assign w_cpl_err  = (w_cpl_resp != RspOk);

  // Decode uses registered busy, so a completion landing this cycle still answers BUSY.
  always_comb begin
    w_code    = RspOk;
    w_rdat    = '0;
    w_ld_addr = 1'b0;
    w_ld_ctrl = 1'b0;
    w_clr     = 1'b0;
    w_go_wr   = 1'b0;
    w_go_rd   = 1'b0;
    if (w_busy && !(w_sel_ctrl && w_rd)) begin
      w_code = RspBusy;
    end else if (bus.dmi_req_i.op == OpNop) begin
      w_code = RspOk;
    end else if (!(w_rd || w_wr) || !(w_sel_addr || w_sel_data || w_sel_ctrl)) begin
      w_code = RspErr;
    end else if (w_sel_addr) begin
      if (w_rd) w_rdat = 32'(r_addr);
      else      w_ld_addr = 1'b1;
    end else if (w_sel_data) begin
      if (w_rd)          w_rdat = r_rdata;
      else if (r_sticky) w_code = RspErr;
      else               w_go_wr = 1'b1;
    end else begin
      if (w_rd) begin
        w_rdat = {27'b0, r_sticky, r_last_resp, r_autoinc, w_busy};
      end else begin
        w_ld_ctrl = 1'b1;
        w_clr     = w_req_data[2];
        if (w_req_data[0]) begin
          if (r_sticky && !w_req_data[2]) w_code = RspErr;
          else                            w_go_rd = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_dmi_state <= Idle;
      r_resp_data <= '0;
      r_resp_code <= '0;
    end else begin
      case (r_dmi_state)
        Idle: if (bus.dmi_req_valid_i) begin
          r_dmi_state <= Resp;
          r_resp_code <= w_code;
          r_resp_data <= w_rdat;
        end
        default: if (bus.dmi_resp_ready_i) r_dmi_state <= Idle;
      endcase
    end
  end

  // DMI side effects only happen when idle and completions only when busy, so they never collide.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_autoinc   <= 1'b0;
      r_sticky    <= 1'b0;
      r_last_resp <= '0;
    end else begin
      if (w_accept && w_ld_addr)
        r_addr <= AxiAddrWidth'(w_req_data);
      else if (w_cpl && !w_cpl_err && r_autoinc)
        r_addr <= r_addr + AxiAddrWidth'(4);
      if (w_accept && w_go_wr)   r_wdata   <= w_req_data;
      if (w_accept && w_ld_ctrl) r_autoinc <= w_req_data[1];
      if (w_accept && w_clr) begin
        r_sticky    <= 1'b0;
        r_last_resp <= '0;
      end else if (w_cpl) begin
        r_last_resp <= w_cpl_resp;
        if (w_cpl_err) r_sticky <= 1'b1;
      end
      if ((r_ax_state == AxR) && bus.axi_rvalid_i) r_rdata <= bus.axi_rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ax_state <= AxIdle;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      case (r_ax_state)
        AxIdle: begin
          if (w_accept && w_go_wr)      r_ax_state <= AxWrite;
          else if (w_accept && w_go_rd) r_ax_state <= AxRead;
        end
        AxWrite: begin
          if ((w_aw_hs || r_aw_done) && (w_w_hs || r_w_done)) begin
            r_ax_state <= AxB;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
          end else begin
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
          end
        end
        AxB:     if (bus.axi_bvalid_i)  r_ax_state <= AxIdle;
        AxRead:  if (bus.axi_arready_i) r_ax_state <= AxR;
        AxR:     if (bus.axi_rvalid_i)  r_ax_state <= AxIdle;
        default: r_ax_state <= AxIdle;
      endcase
    end
  end

  assign bus.dmi_req_ready_o  = (r_dmi_state == Idle);
  assign bus.dmi_resp_valid_o = (r_dmi_state == Resp);
  assign bus.dmi_resp_o       = {r_resp_data, r_resp_code};

  assign bus.axi_awaddr_o  = r_addr;
  assign bus.axi_awvalid_o = (r_ax_state == AxWrite) && !r_aw_done;
  assign bus.axi_wdata_o   = r_wdata;
  assign bus.axi_wstrb_o   = 4'hF;
  assign bus.axi_wvalid_o  = (r_ax_state == AxWrite) && !r_w_done;
  assign bus.axi_bready_o  = (r_ax_state == AxB);
  assign bus.axi_araddr_o  = r_addr;
  assign bus.axi_arvalid_o = (r_ax_state == AxRead);
  assign bus.axi_rready_o  = (r_ax_state == AxR);
endmodule

// File: tb/tb_dmi_axi_lite_bridge.sv
// Directed bench for dmi_axi_lite_bridge: abstract register/transaction model plus AXI slave responder.
module tb_dmi_axi_lite_bridge;
  localparam logic [6:0] A_ADDR = 7'h10;
  localparam logic [6:0] A_DATA = 7'h11;
  localparam logic [6:0] A_CTRL = 7'h12;

  logic clk_i;
  logic rst_ni;
  dmi_axi_lite_bridge_if #(.AxiAddrWidth(32)) bus();

  dmi_axi_lite_bridge #(.AddrBase(7'h10), .AxiAddrWidth(32)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int total = 0;
  int bad   = 0;

  // Abstract model of the register window and the outstanding transaction.
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_autoinc, m_sticky, m_busy, m_kind_wr;
  logic [1:0]  m_last;
  logic [33:0] exp_q[$];

  // Slave configuration and observations.
  int          cfg_aw_delay, cfg_w_delay;
  logic        cfg_ar_hang;
  logic [1:0]  cfg_bresp, cfg_rresp;
  logic [31:0] cfg_rdata;
  int          aw_beats, w_beats, aw_cnt, w_cnt;
  logic        s_aw_hs, s_w_hs, s_b_hs, s_ar_hs, s_r_hs, s_got_aw, s_got_w, s_got_ar;
  logic [31:0] s_awaddr_seen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_addr = '0; m_wdata = '0; m_rdata = '0;
    m_autoinc = 0; m_sticky = 0; m_busy = 0; m_kind_wr = 0; m_last = '0;
  endtask

  task automatic model_access(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d,
                              output logic [1:0] r, output logic [31:0] q);
    r = 2'd0;
    q = '0;
    if (m_busy && !(a == A_CTRL && op == 2'd1)) r = 2'd3;
    else if (op == 2'd0) r = 2'd0;
    else if (op == 2'd3 || a < A_ADDR || a > A_CTRL) r = 2'd2;
    else if (a == A_ADDR) begin
      if (op == 2'd1) q = m_addr; else m_addr = d;
    end else if (a == A_DATA) begin
      if (op == 2'd1) q = m_rdata;
      else if (m_sticky) r = 2'd2;
      else begin m_wdata = d; m_busy = 1; m_kind_wr = 1; end
    end else begin
      if (op == 2'd1) q = {27'b0, m_sticky, m_last, m_autoinc, m_busy};
      else begin
        m_autoinc = d[1];
        if (d[2]) begin m_sticky = 0; m_last = 2'd0; end
        if (d[0]) begin
          if (m_sticky) r = 2'd2;
          else begin m_busy = 1; m_kind_wr = 0; end
        end
      end
    end
  endtask

  task automatic model_complete(input logic [1:0] resp);
    m_last = resp;
    if (resp != 2'd0) m_sticky = 1;
    else if (m_autoinc) m_addr = m_addr + 32'd4;
    m_busy = 0;
  endtask

  task automatic dmi(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d,
                     input int hold, output logic [1:0] r, output logic [31:0] q);
    logic [1:0]  er;
    logic [31:0] eq;
    int n;
    r = '0;
    q = '0;
    @(posedge clk_i); #2;
    bus.dmi_req_i.addr = a;
    bus.dmi_req_i.op   = op;
    bus.dmi_req_i.data = d;
    bus.dmi_req_valid_i = 1'b1;
    n = 0;
    @(negedge clk_i);
    while (!bus.dmi_req_ready_o && n < 50) begin @(negedge clk_i); n++; end
    if (!bus.dmi_req_ready_o) begin
      chk("req_ready_timeout", 64'(bus.dmi_req_ready_o), 64'd1);
      bus.dmi_req_valid_i = 1'b0;
      return;
    end
    model_access(a, op, d, er, eq);
    exp_q.push_back({eq, er});
    @(posedge clk_i); #2;
    bus.dmi_req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("resp_latency", 64'(bus.dmi_resp_valid_o), 64'd1);
    chk("ready_low_in_resp", 64'(bus.dmi_req_ready_o), 64'd0);
    repeat (hold) @(negedge clk_i);
    @(posedge clk_i); #2;
    bus.dmi_resp_ready_i = 1'b1;
    @(negedge clk_i);
    r = bus.dmi_resp_o.resp;
    q = bus.dmi_resp_o.data;
    @(posedge clk_i); #2;
    bus.dmi_resp_ready_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_busy && n < 300) begin @(negedge clk_i); n++; end
    if (m_busy) chk("axi_done_timeout", 64'(m_busy), 64'd0);
  endtask

  // Per-cycle compare against the model.
  initial begin : compare
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        if (bus.dmi_resp_valid_o) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL resp_unexpected actual=%h expected=none", bus.dmi_resp_o);
          end else begin
            chk("resp", 64'(bus.dmi_resp_o), 64'(exp_q[0]));
            if (bus.dmi_resp_ready_i) void'(exp_q.pop_front());
          end
        end
        if (bus.axi_awvalid_o) begin
          chk("aw_pending", {62'd0, m_busy, m_kind_wr}, 64'd3);
          chk("awaddr", 64'(bus.axi_awaddr_o), 64'(m_addr));
        end
        if (bus.axi_wvalid_o) begin
          chk("w_pending", {62'd0, m_busy, m_kind_wr}, 64'd3);
          chk("wdata", 64'(bus.axi_wdata_o), 64'(m_wdata));
          chk("wstrb", 64'(bus.axi_wstrb_o), 64'hF);
        end
        if (bus.axi_arvalid_o) begin
          chk("ar_pending", {62'd0, m_busy, m_kind_wr}, 64'd2);
          chk("araddr", 64'(bus.axi_araddr_o), 64'(m_addr));
        end
      end
    end
  end

  // AXI slave: samples handshakes at negedge, reacts just after the following posedge.
  initial begin : slave
    bus.axi_awready_i = 0; bus.axi_wready_i = 0; bus.axi_bvalid_i = 0; bus.axi_bresp_i = 0;
    bus.axi_arready_i = 0; bus.axi_rvalid_i = 0; bus.axi_rdata_i = 0; bus.axi_rresp_i = 0;
    aw_cnt = 0; w_cnt = 0; s_got_aw = 0; s_got_w = 0; s_got_ar = 0;
    forever begin
      @(negedge clk_i);
      s_aw_hs = bus.axi_awvalid_o && bus.axi_awready_i;
      s_w_hs  = bus.axi_wvalid_o && bus.axi_wready_i;
      s_b_hs  = bus.axi_bvalid_i && bus.axi_bready_o;
      s_ar_hs = bus.axi_arvalid_o && bus.axi_arready_i;
      s_r_hs  = bus.axi_rvalid_i && bus.axi_rready_o;
      if (s_aw_hs) s_awaddr_seen = bus.axi_awaddr_o;
      @(posedge clk_i); #1;
      if (!rst_ni) begin
        bus.axi_awready_i = 0; bus.axi_wready_i = 0; bus.axi_bvalid_i = 0;
        bus.axi_arready_i = 0; bus.axi_rvalid_i = 0;
        aw_cnt = 0; w_cnt = 0; s_got_aw = 0; s_got_w = 0; s_got_ar = 0;
      end else begin
        if (s_aw_hs) begin aw_beats++; s_got_aw = 1; aw_cnt = 0; end
        if (s_w_hs)  begin w_beats++;  s_got_w  = 1; w_cnt  = 0; end
        if (s_b_hs)  begin bus.axi_bvalid_i = 0; model_complete(bus.axi_bresp_i); end
        if (s_ar_hs) s_got_ar = 1;
        if (s_r_hs) begin
          bus.axi_rvalid_i = 0;
          m_rdata = bus.axi_rdata_i;
          model_complete(bus.axi_rresp_i);
        end
        if (s_got_aw && s_got_w) begin
          bus.axi_bvalid_i = 1; bus.axi_bresp_i = cfg_bresp; s_got_aw = 0; s_got_w = 0;
        end
        if (s_got_ar) begin
          bus.axi_rvalid_i = 1; bus.axi_rdata_i = cfg_rdata; bus.axi_rresp_i = cfg_rresp; s_got_ar = 0;
        end
        bus.axi_awready_i = bus.axi_awvalid_o && (aw_cnt >= cfg_aw_delay);
        if (bus.axi_awvalid_o) aw_cnt++;
        bus.axi_wready_i = bus.axi_wvalid_o && (w_cnt >= cfg_w_delay);
        if (bus.axi_wvalid_o) w_cnt++;
        bus.axi_arready_i = bus.axi_arvalid_o && !cfg_ar_hang;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [1:0]  r;
    logic [31:0] q;
    int          aw0;
    rst_ni = 1'b0;
    bus.dmi_req_i = '0; bus.dmi_req_valid_i = 1'b0; bus.dmi_resp_ready_i = 1'b0;
    cfg_aw_delay = 0; cfg_w_delay = 0; cfg_ar_hang = 0;
    cfg_bresp = 0; cfg_rresp = 0; cfg_rdata = 0;
    aw_beats = 0; w_beats = 0; s_awaddr_seen = 0;
    model_reset();
    #12;
    chk("rst_req_ready", 64'(bus.dmi_req_ready_o), 64'd1);
    chk("rst_resp_valid", 64'(bus.dmi_resp_valid_o), 64'd0);
    chk("rst_resp", 64'(bus.dmi_resp_o), 64'd0);
    chk("rst_axi_valids", {59'd0, bus.axi_awvalid_o, bus.axi_wvalid_o, bus.axi_arvalid_o,
                           bus.axi_bready_o, bus.axi_rready_o}, 64'd0);
    #10 rst_ni = 1'b1;

    // ADDR write/read, response held while not consumed
    dmi(A_ADDR, 2'd2, 32'h8000_0000, 0, r, q);
    chk("t1_addr_wr_resp", 64'(r), 64'd0);
    dmi(A_ADDR, 2'd1, 32'h0, 3, r, q);
    chk("t1_addr_rd", {30'd0, q, r}, {30'd0, 32'h8000_0000, 2'd0});

    // DATA write with delayed awready
    cfg_aw_delay = 2; cfg_w_delay = 0; cfg_bresp = 2'd0;
    aw_beats = 0; w_beats = 0;
    dmi(A_DATA, 2'd2, 32'hCAFE_F00D, 0, r, q);
    chk("t2_data_wr_resp", 64'(r), 64'd0);
    wait_idle();
    repeat (3) @(negedge clk_i);
    chk("t2_aw_beats", 64'(aw_beats), 64'd1);
    chk("t2_w_beats", 64'(w_beats), 64'd1);
    chk("t2_awaddr", 64'(s_awaddr_seen), 64'h8000_0000);
    dmi(A_CTRL, 2'd1, 32'h0, 0, r, q);
    chk("t2_ctrl_rd", {30'd0, q, r}, {30'd0, 32'h0, 2'd0});

    // AXI read with autoinc, then wrap at the top of the address space
    cfg_rdata = 32'h1234_5678; cfg_rresp = 2'd0; cfg_aw_delay = 0;
    dmi(A_CTRL, 2'd2, 32'h3, 0, r, q);
    chk("t3_ctrl_wr_resp", 64'(r), 64'd0);
    wait_idle();
    dmi(A_DATA, 2'd1, 32'h0, 0, r, q);
    chk("t3_rdata", {30'd0, q, r}, {30'd0, 32'h1234_5678, 2'd0});
    dmi(A_ADDR, 2'd1, 32'h0, 0, r, q);
    chk("t3_addr_inc", 64'(q), 64'h8000_0004);
    dmi(A_ADDR, 2'd2, 32'hFFFF_FFFC, 0, r, q);
    dmi(A_CTRL, 2'd2, 32'h3, 0, r, q);
    wait_idle();
    dmi(A_ADDR, 2'd1, 32'h0, 0, r, q);
    chk("t3_addr_wrap", 64'(q), 64'h0);

    // Hung AR: everything but CTRL read is BUSY
    dmi(A_ADDR, 2'd2, 32'h2000_0000, 0, r, q);
    cfg_ar_hang = 1;
    dmi(A_CTRL, 2'd2, 32'h1, 0, r, q);
    chk("t4_launch", 64'(r), 64'd0);
    dmi(A_DATA, 2'd1, 32'h0, 0, r, q);
    chk("t4_data_rd_busy", {30'd0, q, r}, {30'd0, 32'h0, 2'd3});
    dmi(A_ADDR, 2'd2, 32'h55, 0, r, q);
    chk("t4_addr_wr_busy", 64'(r), 64'd3);
    dmi(A_CTRL, 2'd1, 32'h0, 0, r, q);
    chk("t4_ctrl_busy", {30'd0, q, r}, {30'd0, 32'h1, 2'd0});
    cfg_ar_hang = 0;
    wait_idle();
    dmi(A_ADDR, 2'd1, 32'h0, 0, r, q);
    chk("t4_addr_kept", 64'(q), 64'h2000_0000);

    // SLVERR: sticky error blocks launches until cleared
    cfg_bresp = 2'd2;
    dmi(A_DATA, 2'd2, 32'h11, 0, r, q);
    wait_idle();
    dmi(A_CTRL, 2'd1, 32'h0, 0, r, q);
    chk("t5_ctrl_err", 64'(q), 64'h18);
    aw0 = aw_beats;
    dmi(A_DATA, 2'd2, 32'h22, 0, r, q);
    chk("t5_data_wr_err", 64'(r), 64'd2);
    repeat (5) @(negedge clk_i);
    chk("t5_no_aw", 64'(aw_beats), 64'(aw0));
    dmi(A_CTRL, 2'd2, 32'h3, 0, r, q);
    chk("t5_ctrl_launch_err", 64'(r), 64'd2);
    dmi(A_CTRL, 2'd1, 32'h0, 0, r, q);
    chk("t5_ctrl_autoinc_kept", 64'(q), 64'h1A);
    dmi(A_CTRL, 2'd2, 32'h4, 0, r, q);
    chk("t5_clear", 64'(r), 64'd0);
    cfg_bresp = 2'd0;
    dmi(A_DATA, 2'd2, 32'h33, 0, r, q);
    chk("t5_data_wr_ok", 64'(r), 64'd0);
    wait_idle();
    chk("t5_aw_issued", 64'(aw_beats), 64'(aw0 + 1));

    // Unmapped address, then asynchronous reset mid-write
    dmi(7'h05, 2'd1, 32'h0, 0, r, q);
    chk("t6_unmapped", {30'd0, q, r}, {30'd0, 32'h0, 2'd2});
    cfg_aw_delay = 50;
    dmi(A_DATA, 2'd2, 32'h77, 0, r, q);
    @(negedge clk_i);
    chk("t6_aw_pending", 64'(bus.axi_awvalid_o), 64'd1);
    #3 rst_ni = 1'b0;
    #1;
    chk("t6_rst_awvalid", 64'(bus.axi_awvalid_o), 64'd0);
    chk("t6_rst_wvalid", 64'(bus.axi_wvalid_o), 64'd0);
    chk("t6_rst_req_ready", 64'(bus.dmi_req_ready_o), 64'd1);
    model_reset();
    exp_q.delete();
    cfg_aw_delay = 0;
    @(negedge clk_i);
    #3 rst_ni = 1'b1;
    dmi(A_ADDR, 2'd1, 32'h0, 0, r, q);
    chk("t6_addr_after_rst", {30'd0, q, r}, {30'd0, 32'h0, 2'd0});

    repeat (3) @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
